fifo_rd_ctrl: RTL and testbench

//   Read-side controller for the 16x5 FIFO storage RAM (synchronous read, 1-cycle latency).

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_rd_ctrl_if.sv | 13 +
 rtl/fifo_skid2.sv | 70 +++++++
 rtl/fifo_rd_ctrl.sv | 68 ++++++
 tb/tb_fifo_rd_ctrl.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared types and sizing for the FIFO read path: 16-word x 5-bit storage,
// pointers carry one extra wrap bit to tell full from empty.
package fifo_pkg;
  localparam int ADDR  = 4;
  localparam int DW    = 5;
  localparam int DEPTH = 2 ** ADDR;

  typedef logic [ADDR:0]   ptr_t;
  typedef logic [DW-1:0]   data_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return p + ptr_t'(1);
  endfunction
endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Output stream of the FIFO read controller.
// Handshake: a word transfers on a rising edge where m_valid & m_ready; m_valid
// never depends on m_ready, and m_data holds steady while m_valid & ~m_ready.
interface fifo_rd_ctrl_if;
  import fifo_pkg::*;

  logic  m_valid;
  data_t m_data;
  logic  m_ready;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/fifo_skid2.sv
// Two-entry in-order buffer that absorbs RAM read data; entry 0 is always the head.
// The EMPTY/ONE/TWO state doubles as the occupancy count.
module fifo_skid2
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  data_t      din,
  input  logic       pop,
  output data_t      dout,
  output logic [1:0] occ
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0] state;
  data_t      ent0;
  data_t      ent1;
  logic       do_pop;

  assign do_pop = pop & (state != S_EMPTY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_EMPTY;
      ent0  <= '0;
      ent1  <= '0;
    end else if (clr) begin
      state <= S_EMPTY;
      ent0  <= '0;
      ent1  <= '0;
    end else begin
      case (state)
        S_EMPTY: begin
          if (push) begin
            ent0  <= din;
            state <= S_ONE;
          end
        end
        S_ONE: begin
          case ({push, do_pop})
            2'b10: begin
              ent1  <= din;
              state <= S_TWO;
            end
            2'b01: state <= S_EMPTY;
            2'b11: ent0 <= din;   // head leaves as the new word arrives
            default: ;
          endcase
        end
        S_TWO: begin
          if (do_pop) begin
            ent0 <= ent1;
            if (push) ent1 <= din;
            else      state <= S_ONE;
          end
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

  assign dout = ent0;
  assign occ  = state;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: fetches RAM words ahead of demand, hides the
// one-cycle RAM read latency behind a 2-entry skid buffer, reports rd_ptr back.
module fifo_rd_ctrl
  import fifo_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  ptr_t              wr_ptr,
  output ptr_t              rd_ptr,
  output logic [ADDR-1:0]   mem_addr_rd,
  input  data_t             mem_data,
  fifo_rd_ctrl_if.master    stream,
  output logic              empty,
  output ptr_t              level,
  output logic [1:0]        occ,
  output logic              inflight
);

  ptr_t       rd_q;
  logic       infl_q;
  logic [1:0] occ_w;
  data_t      head;
  logic       avail;
  logic       pop;
  logic       issue;
  logic       capture;
  logic [2:0] demand;

  assign avail  = (rd_q != wr_ptr);
  assign pop    = stream.m_valid & stream.m_ready;
  // Words already committed to the buffer after this edge; must leave room for one more.
  assign demand = {1'b0, occ_w} + {2'b00, infl_q} - {2'b00, pop};
  assign issue  = avail & ~flush & (demand < 3'd2);
  assign capture = infl_q & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q   <= '0;
      infl_q <= 1'b0;
    end else begin
      if (flush)      rd_q <= wr_ptr;
      else if (issue) rd_q <= ptr_inc(rd_q);
      infl_q <= issue;
    end
  end

  fifo_skid2 u_skid (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (flush),
    .push (capture),
    .din  (mem_data),
    .pop  (pop),
    .dout (head),
    .occ  (occ_w)
  );

  assign stream.m_valid = (occ_w != 2'd0);
  assign stream.m_data  = head;
  assign empty          = ~stream.m_valid;
  assign rd_ptr         = rd_q;
  assign mem_addr_rd    = rd_q[ADDR-1:0];
  assign level          = (wr_ptr - rd_q) + {{ADDR{1'b0}}, infl_q} + {{(ADDR-1){1'b0}}, occ_w};
  assign occ            = occ_w;
  assign inflight       = infl_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural sync-read RAM, scoreboard queue fed as words
// are written and drained as the stream hands words over.
module tb_fifo_rd_ctrl;
  import fifo_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            flush = 1'b0;
  ptr_t            wr_ptr = '0;
  ptr_t            rd_ptr;
  logic [ADDR-1:0] mem_addr_rd;
  data_t           mem_data;
  logic            empty;
  ptr_t            level;
  logic [1:0]      occ;
  logic            inflight;

  fifo_rd_ctrl_if stream ();

  fifo_rd_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .wr_ptr     (wr_ptr),
    .rd_ptr     (rd_ptr),
    .mem_addr_rd(mem_addr_rd),
    .mem_data   (mem_data),
    .stream     (stream),
    .empty      (empty),
    .level      (level),
    .occ        (occ),
    .inflight   (inflight)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required normal completion");
    $fatal(1);
  end

  // ---------------- RAM model ----------------
  data_t mem [DEPTH];
  always @(posedge clk) mem_data <= mem[mem_addr_rd];

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  ptr_t          wr_stage = '0;
  logic [DW-1:0] exp_d;

  always @(negedge clk) begin
    if (rst_n && !flush && stream.m_valid && stream.m_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_extra: m_data=%0d handed over, required no word", stream.m_data);
      end else begin
        exp_d = exp_q.pop_front();
        if (stream.m_data !== exp_d) begin
          n_fail++;
          $display("FAIL sb_data: m_data=%0d, required %0d", stream.m_data, exp_d);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    stream.m_ready = 1'b0;
    wr_ptr = '0;
    wr_stage = '0;
    exp_q.delete();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic put_word(input data_t v);
    mem[wr_stage[ADDR-1:0]] = v;
    exp_q.push_back(v);
    wr_stage = ptr_inc(wr_stage);
  endtask

  task automatic put_random(input int n);
    for (int i = 0; i < n; i++) put_word(data_t'($urandom_range(0, 31)));
  endtask

  task automatic commit();
    wr_ptr = wr_stage;
  endtask

  task automatic wait_drained(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (exp_q.size() == 0 && !stream.m_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    repeat (3) step();
    n_checks++; if (rd_ptr !== 5'd0)       begin n_fail++; $display("FAIL reset_rd_ptr: got %0d, required 0", rd_ptr); end
    n_checks++; if (stream.m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b, required 0", stream.m_valid); end
    n_checks++; if (empty !== 1'b1)        begin n_fail++; $display("FAIL reset_empty: got %b, required 1", empty); end
    n_checks++; if (level !== 5'd0)        begin n_fail++; $display("FAIL reset_level: got %0d, required 0", level); end
    n_checks++; if (mem_addr_rd !== 4'd0)  begin n_fail++; $display("FAIL reset_addr: got %0d, required 0", mem_addr_rd); end
    n_checks++; if (inflight !== 1'b0)     begin n_fail++; $display("FAIL reset_no_issue: inflight=%b, required 0", inflight); end
    n_checks++; if (stream.m_data !== 5'd0) begin n_fail++; $display("FAIL reset_m_data: got %0d, required 0", stream.m_data); end
  endtask

  task automatic test_in_order();
    int first;
    int nvalid;
    apply_reset();
    stream.m_ready = 1'b1;
    put_word(5'd3);
    put_word(5'd7);
    put_word(5'd9);
    commit();
    first = -1;
    nvalid = 0;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (stream.m_valid) begin
        nvalid++;
        if (first < 0) first = c;
      end
    end
    n_checks++; if (first !== 2)  begin n_fail++; $display("FAIL latency: first valid after %0d clocks, required 2", first); end
    n_checks++; if (nvalid !== 3) begin n_fail++; $display("FAIL burst_len: %0d valid clocks, required 3", nvalid); end
    n_checks++; if (rd_ptr !== 5'd3) begin n_fail++; $display("FAIL in_order_rd_ptr: got %0d, required 3", rd_ptr); end
    n_checks++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL in_order_left: %0d words undelivered, required 0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] head;
    int cnt;
    bit ok;
    apply_reset();
    stream.m_ready = 1'b0;
    put_random(10);
    commit();
    head = exp_q[0];
    repeat (6) step();
    n_checks++; if (occ !== 2'd2)     begin n_fail++; $display("FAIL bp_occ: got %0d, required 2", occ); end
    n_checks++; if (rd_ptr !== 5'd2)  begin n_fail++; $display("FAIL bp_rd_ptr: got %0d, required 2", rd_ptr); end
    n_checks++; if (level !== 5'd10)  begin n_fail++; $display("FAIL bp_level: got %0d, required 10", level); end
    n_checks++; if (inflight !== 1'b0) begin n_fail++; $display("FAIL bp_inflight: got %b, required 0", inflight); end
    n_checks++; if (stream.m_data !== head) begin n_fail++; $display("FAIL bp_head: got %0d, required %0d", stream.m_data, head); end
    repeat (3) step();
    n_checks++; if (stream.m_data !== head) begin n_fail++; $display("FAIL bp_stable: got %0d, required %0d", stream.m_data, head); end
    stream.m_ready = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (stream.m_valid) cnt++;
      step();
    end
    n_checks++; if (cnt !== 10) begin n_fail++; $display("FAIL throughput: %0d words in 10 clocks, required 10", cnt); end
    wait_drained(5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_drain: %0d words left, required 0", exp_q.size()); end
    n_checks++; if (level !== 5'd0) begin n_fail++; $display("FAIL bp_level_end: got %0d, required 0", level); end
  endtask

  task automatic test_wrap();
    bit ok;
    apply_reset();
    stream.m_ready = 1'b1;
    put_random(15);
    commit();
    wait_drained(60, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_pre_drain: %0d words left, required 0", exp_q.size()); end
    n_checks++; if (rd_ptr !== 5'd15) begin n_fail++; $display("FAIL wrap_start: rd_ptr=%0d, required 15", rd_ptr); end
    n_checks++; if (mem_addr_rd !== 4'd15) begin n_fail++; $display("FAIL wrap_addr15: got %0d, required 15", mem_addr_rd); end
    put_random(2);
    commit();
    step();
    n_checks++; if (mem_addr_rd !== 4'd0) begin n_fail++; $display("FAIL wrap_addr0: got %0d, required 0", mem_addr_rd); end
    step();
    n_checks++; if (rd_ptr !== 5'b10001) begin n_fail++; $display("FAIL wrap_rd_ptr: got %b, required 10001", rd_ptr); end
    wait_drained(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL wrap_drain: %0d words left, required 0", exp_q.size()); end
  endtask

  task automatic test_flush();
    bit ok;
    apply_reset();
    stream.m_ready = 1'b0;
    put_random(12);
    commit();
    repeat (6) step();
    stream.m_ready = 1'b1;
    step();
    n_checks++; if (occ !== 2'd1 || inflight !== 1'b1) begin n_fail++; $display("FAIL flush_setup: occ=%0d inflight=%b, required 1/1", occ, inflight); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    exp_q.delete();
    n_checks++; if (stream.m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b, required 0", stream.m_valid); end
    n_checks++; if (rd_ptr !== 5'd12) begin n_fail++; $display("FAIL flush_rd_ptr: got %0d, required 12", rd_ptr); end
    n_checks++; if (level !== 5'd0)   begin n_fail++; $display("FAIL flush_level: got %0d, required 0", level); end
    n_checks++; if (occ !== 2'd0 || inflight !== 1'b0) begin n_fail++; $display("FAIL flush_state: occ=%0d inflight=%b, required 0/0", occ, inflight); end
    repeat (3) step();
    n_checks++; if (stream.m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_late_data: m_valid=%b, required 0", stream.m_valid); end
    put_random(2);
    commit();
    wait_drained(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_resume: %0d words left, required 0", exp_q.size()); end
    n_checks++; if (rd_ptr !== 5'd14) begin n_fail++; $display("FAIL flush_resume_ptr: got %0d, required 14", rd_ptr); end
  endtask

  task automatic test_async_reset();
    bit ok;
    apply_reset();
    stream.m_ready = 1'b0;
    put_random(3);
    commit();
    step();
    step();
    n_checks++; if (occ !== 2'd1) begin n_fail++; $display("FAIL areset_setup: occ=%0d, required 1", occ); end
    #1;
    rst_n = 1'b0;
    wr_ptr = '0;
    #1;
    n_checks++; if (stream.m_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b, required 0", stream.m_valid); end
    n_checks++; if (rd_ptr !== 5'd0)  begin n_fail++; $display("FAIL areset_rd_ptr: got %0d, required 0", rd_ptr); end
    n_checks++; if (level !== 5'd0)   begin n_fail++; $display("FAIL areset_level: got %0d, required 0", level); end
    n_checks++; if (stream.m_data !== 5'd0 || inflight !== 1'b0) begin n_fail++; $display("FAIL areset_clear: m_data=%0d inflight=%b, required 0/0", stream.m_data, inflight); end
    exp_q.delete();
    wr_stage = '0;
    step();
    rst_n = 1'b1;
    step();
    stream.m_ready = 1'b1;
    put_random(2);
    commit();
    wait_drained(20, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL areset_restart: %0d words left, required 0", exp_q.size()); end
    n_checks++; if (rd_ptr !== 5'd2) begin n_fail++; $display("FAIL areset_rd_ptr_end: got %0d, required 2", rd_ptr); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    stream.m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    test_reset();
    test_in_order();
    test_backpressure();
    test_wrap();
    test_flush();
    test_async_reset();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
